mandel_engine_scheduler: RTL and testbench
==========================================

Name: mandel_engine_scheduler

Overview:
- Sequences a bank of N depth_calculator engines for the Mandelbrot pixel generator.
- Issues pixel coordinates in raster order, round-robin across the engines, and collects each engine's final_depth.
- Presents the results strictly in raster order on a valid/ready stream to the colour mapping and packer stage, with sof/eol flags.
- Replaces the single-engine start/done loop and the raster counters in the pixel generator.

Parameters:
- N_ENGINES, 4, number of depth engines (2..8).
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- DEPTH_W, 8, width of final_depth.

Ports:
- sysclk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits dispatch of new pixels; a frame continues past its end while held high.
- eng_start  out  N_ENGINES  one-cycle start pulse, one bit per engine.
- eng_x  out  10  pixel X, shared by all engines; valid only in the start cycle.
- eng_y  out  9  pixel Y, shared by all engines; valid only in the start cycle.
- eng_done  in  N_ENGINES  one-cycle done pulse, one bit per engine.
- eng_depth  in  N_ENGINES*DEPTH_W  packed final_depth; engine i occupies slice [i*DEPTH_W +: DEPTH_W].
- out_depth  out  DEPTH_W  depth of the current output pixel.
- out_x  out  10  X of the output pixel.
- out_y  out  9  Y of the output pixel.
- out_sof  out  1  output pixel is (0,0).
- out_eol  out  1  output pixel has X = X_SIZE-1.
- out_valid  out  1  output pixel is available.
- out_ready  in  1  downstream accepts the output pixel.
- busy  out  1  any engine is BUSY or DONE.
- proto_err  out  1  sticky flag: done received from an engine that was not BUSY.

Behaviour:
- Reset values:
  - all outputs 0;
  - every engine slot IDLE;
  - dispatch pointer dp=0, output pointer op=0;
  - dispatch counters dx=dy=0, output counters ox=oy=0.
- Per-slot state machine, one per engine:
  - IDLE -> BUSY when the slot is dispatched.
  - BUSY -> DONE on eng_done[i]; eng_depth slice i is latched into res[i] in the same edge.
  - DONE -> IDLE when the slot's pixel is accepted (out_valid & out_ready with op==i).
- Dispatch:
  - Condition: enable=1 and slot[dp]==IDLE at the current cycle.
  - Action: eng_start[dp]=1 for exactly one cycle (registered), with eng_x=dx and eng_y=dy in that same cycle.
  - Next edge: slot[dp] becomes BUSY, dp advances modulo N_ENGINES, and (dx,dy) advance in raster order.
  - Raster wrap: X_SIZE-1 goes to 0 with dy incremented; (X_SIZE-1, Y_SIZE-1) goes to (0,0).
  - At most one dispatch per cycle.
  - Dispatch stalls whenever slot[dp] is not IDLE, so pixel k always runs on engine k mod N_ENGINES.
- Output:
  - out_valid = (slot[op]==DONE), registered.
  - out_depth = res[op]; out_x/out_y = ox/oy.
  - out_sof = (ox==0 && oy==0); out_eol = (ox==X_SIZE-1).
  - All outputs hold stable while out_valid=1 and out_ready=0.
  - On acceptance, op and (ox,oy) advance with the same wrap rules as dispatch.
- Latency:
  - Minimum from eng_done[i] to out_valid is 1 cycle (when op==i).
  - A slot freed by acceptance in cycle t can be re-dispatched no earlier than cycle t+1; no same-cycle reuse.
- Simultaneous events:
  - Multiple eng_done bits in one cycle are all latched.
  - done and acceptance on different slots in the same cycle are independent.
  - Dispatch and acceptance on the same cycle are allowed, each on its own slot.
- Out-of-protocol done: eng_done[i] while slot i is IDLE or DONE is ignored (res[i] unchanged) and sets proto_err. proto_err clears only on reset.
- enable deasserted mid-frame:
  - Dispatch stops immediately; in-flight pixels still complete and drain in order.
  - Re-asserting enable resumes from the held dx/dy.
- Reset mid-operation: all state returns to reset values asynchronously. Engines are reset by the same signal, so no stale done pulse may be counted.
- Widths: counters are 10/9 bits; X_SIZE ≤ 1024 and Y_SIZE ≤ 512 are checked at elaboration.

Decomposition:
- Shared package mandel_pkg:
  - slot state enum (IDLE, BUSY, DONE);
  - constants X_SIZE, Y_SIZE, DEPTH_W, X_W=10, Y_W=9;
  - raster_next function returning the next (x,y) with wrap.
- One natural sub-module, raster_counter: an (x,y) raster counter with advance/wrap, instantiated twice (dispatch and output).

Test Plan (overrides: N_ENGINES=4, X_SIZE=4, Y_SIZE=2; out_ready=1 unless stated):
- Reset, then enable=1, engines respond with done after fixed 5 cycles, depth=x+4y -> starts issued to engines 0,1,2,3 with (0,0),(1,0),(2,0),(3,0) on consecutive cycles; outputs depth 0..7 in order; sof on pixel 0 and pixel 8; eol on x=3.
- Engine done delays 9,2,2,2 cycles -> engines 1-3 are held in DONE; the first out_valid follows engine 0's done by 1 cycle; the output sequence is still 0,1,2,3.
- out_ready=0 for 20 cycles after the first result -> out_depth, out_x and out_y stay stable; no further starts after 4 are in flight; traffic resumes in order when out_ready returns to 1.
- enable dropped after 3 starts -> no 4th start; 3 outputs drain; busy falls to 0; re-enable issues (3,0) to engine 3.
- Spurious eng_done[2] while slot 2 is IDLE -> proto_err=1 and stays set; the output stream is unaffected.
- Reset asserted while 4 engines are BUSY -> all outputs are 0 immediately; after release the first start carries (0,0) on engine 0.

Source files
------------

// File: rtl/mandel_engine_scheduler_pkg.sv
// Shared types and raster helpers for the Mandelbrot engine scheduler.
package mandel_pkg;

  localparam int X_SIZE  = 640;
  localparam int Y_SIZE  = 480;
  localparam int DEPTH_W = 8;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } raster_t;

  // Next pixel in raster order; the last pixel of a frame wraps to (0,0).
  function automatic raster_t raster_next(raster_t p, int xs, int ys);
    raster_t n;
    n = p;
    if (p.x == X_W'(xs - 1)) begin
      n.x = '0;
      n.y = (p.y == Y_W'(ys - 1)) ? '0 : p.y + 1'b1;
    end else begin
      n.x = p.x + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mandel_engine_scheduler_if.sv
// Engine-bank and output-stream bundle between the scheduler and its neighbours.
interface mandel_engine_scheduler_if #(
  parameter int N_ENGINES = 4,
  parameter int DEPTH_W   = 8
);
  logic                           enable;
  logic [N_ENGINES-1:0]           eng_start;
  logic [mandel_pkg::X_W-1:0]     eng_x;
  logic [mandel_pkg::Y_W-1:0]     eng_y;
  logic [N_ENGINES-1:0]           eng_done;
  logic [N_ENGINES*DEPTH_W-1:0]   eng_depth;
  logic [DEPTH_W-1:0]             out_depth;
  logic [mandel_pkg::X_W-1:0]     out_x;
  logic [mandel_pkg::Y_W-1:0]     out_y;
  logic                           out_sof;
  logic                           out_eol;
  logic                           out_valid;
  logic                           out_ready;
  logic                           busy;
  logic                           proto_err;

  modport master (
    input  enable, eng_done, eng_depth, out_ready,
    output eng_start, eng_x, eng_y, out_depth, out_x, out_y,
           out_sof, out_eol, out_valid, busy, proto_err
  );

  modport slave (
    output enable, eng_done, eng_depth, out_ready,
    input  eng_start, eng_x, eng_y, out_depth, out_x, out_y,
           out_sof, out_eol, out_valid, busy, proto_err
  );
endinterface

// File: rtl/mandel_engine_scheduler_raster_counter.sv
// (x,y) raster position counter; pos_d exposes the value it will take at the next edge.
module raster_counter
  import mandel_pkg::*;
#(
  parameter int XS = 640,
  parameter int YS = 480
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    adv,
  output raster_t pos,
  output raster_t pos_d
);
  assign pos_d = adv ? raster_next(pos, XS, YS) : pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos <= '0;
    else     pos <= pos_d;
  end
endmodule

// File: rtl/mandel_engine_scheduler.sv
// Round-robin dispatcher for a bank of depth engines; results are re-ordered into raster order.
module mandel_engine_scheduler #(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE    = mandel_pkg::X_SIZE,
  parameter int Y_SIZE    = mandel_pkg::Y_SIZE,
  parameter int DEPTH_W   = mandel_pkg::DEPTH_W
) (
  input logic sysclk,
  input logic reset,
  mandel_engine_scheduler_if.master bus
);
  import mandel_pkg::*;

  localparam int PW = $clog2(N_ENGINES);

  if (X_SIZE > 1024 || Y_SIZE > 512 || N_ENGINES < 2 || N_ENGINES > 8) begin : g_bad_cfg
    $error("mandel_engine_scheduler: unsupported size parameters");
  end

  slot_e [N_ENGINES-1:0]               slot_q, slot_d;
  logic  [N_ENGINES-1:0][DEPTH_W-1:0]  res_q, res_d;
  logic  [PW-1:0]                      dp, dp_d, op, op_d;
  raster_t                             dpos, dpos_d, opos, opos_d;
  logic                                disp, acc, perr_d, busy_d;

  // Pixel k is pinned to engine k mod N, so dispatch waits on the pointed slot only.
  assign disp = bus.enable && (slot_q[dp] == IDLE);
  assign acc  = bus.out_valid && bus.out_ready;
  assign dp_d = disp ? ((dp == PW'(N_ENGINES - 1)) ? '0 : dp + 1'b1) : dp;
  assign op_d = acc  ? ((op == PW'(N_ENGINES - 1)) ? '0 : op + 1'b1) : op;

  raster_counter #(.XS(X_SIZE), .YS(Y_SIZE)) u_disp_ctr (
    .clk(sysclk), .rst(reset), .adv(disp), .pos(dpos), .pos_d(dpos_d)
  );

  raster_counter #(.XS(X_SIZE), .YS(Y_SIZE)) u_out_ctr (
    .clk(sysclk), .rst(reset), .adv(acc), .pos(opos), .pos_d(opos_d)
  );

  always_comb begin
    slot_d = slot_q;
    res_d  = res_q;
    perr_d = bus.proto_err;
    busy_d = 1'b0;
    for (int i = 0; i < N_ENGINES; i++) begin
      case (slot_q[i])
        IDLE: if (disp && dp == PW'(i)) slot_d[i] = BUSY;
        BUSY: if (bus.eng_done[i]) begin
          slot_d[i] = DONE;
          res_d[i]  = bus.eng_depth[i*DEPTH_W +: DEPTH_W];
        end
        DONE: if (acc && op == PW'(i)) slot_d[i] = IDLE;
        default: slot_d[i] = IDLE;
      endcase
      // A done on a slot that has nothing outstanding is dropped but remembered.
      if (bus.eng_done[i] && slot_q[i] != BUSY) perr_d = 1'b1;
      if (slot_d[i] != IDLE) busy_d = 1'b1;
    end
  end

  // Outputs are registered from next-state so a done shows up after one edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ENGINES; i++) slot_q[i] <= IDLE;
      res_q         <= '0;
      dp            <= '0;
      op            <= '0;
      bus.eng_start <= '0;
      bus.eng_x     <= '0;
      bus.eng_y     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_depth <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      res_q         <= res_d;
      dp            <= dp_d;
      op            <= op_d;
      bus.eng_start <= disp ? (N_ENGINES'(1) << dp) : '0;
      bus.eng_x     <= disp ? dpos.x : '0;
      bus.eng_y     <= disp ? dpos.y : '0;
      bus.out_valid <= (slot_d[op_d] == DONE);
      bus.out_depth <= res_d[op_d];
      bus.out_x     <= opos_d.x;
      bus.out_y     <= opos_d.y;
      bus.out_sof   <= (opos_d.x == '0) && (opos_d.y == '0);
      bus.out_eol   <= (opos_d.x == X_W'(X_SIZE - 1));
      bus.busy      <= busy_d;
      bus.proto_err <= perr_d;
    end
  end
endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// Randomized bench: engine bank model plus a raster-order reference for the result stream.
module tb_mandel_engine_scheduler;
  localparam int N  = 4;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int DW = 8;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  mandel_engine_scheduler_if #(.N_ENGINES(N), .DEPTH_W(DW)) bus ();

  mandel_engine_scheduler #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) dut (
    .sysclk(sysclk), .reset(reset), .bus(bus)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp, n_bad, cyc;
  int start_cnt, out_cnt;
  bit last_acc;
  int done_at [0:1023];
  bit eact [N];
  int ecnt [N];
  int epix [N];
  logic [DW-1:0] edep [N];
  int dly [N];
  bit rand_dly;
  int rdy_mode;
  bit spur, exp_perr;
  int start_cyc [4];
  int first_valid_cyc, first_done0_cyc, last_sx, last_se;

  task automatic clear_model();
    start_cnt = 0; out_cnt = 0; last_acc = 0; exp_perr = 0; spur = 0;
    first_valid_cyc = -1; first_done0_cyc = -1; last_sx = -1; last_se = -1;
    for (int i = 0; i < 1024; i++) done_at[i] = -1;
    for (int i = 0; i < N; i++) begin eact[i] = 0; ecnt[i] = 0; end
    for (int i = 0; i < 4; i++) start_cyc[i] = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.eng_done = '0; bus.out_ready = 1'b1;
    clear_model();
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
  endtask

  // One clock: observe what the DUT shows this cycle, then drive the next inputs.
  task automatic step();
    bit en_edge, rdy, exp_v;
    int acc_before, k, j;
    logic [N-1:0] exp_st, dn;
    logic [N*DW-1:0] dep;
    logic [DW-1:0] exp_d;
    en_edge = bus.enable;
    @(negedge sysclk);
    cyc++;
    acc_before = out_cnt - (last_acc ? 1 : 0);
    if (bus.eng_start != '0) begin
      k = start_cnt;
      exp_st = '0; exp_st[k % N] = 1'b1;
      n_cmp++;
      if (bus.eng_start !== exp_st || bus.eng_x !== 10'(k % XS) || bus.eng_y !== 9'((k / XS) % YS)
          || !en_edge || k >= acc_before + N) begin
        n_bad++;
        $display("FAIL start[%0d]: got start=%b xy=(%0d,%0d) en=%0b freed=%0d, want start=%b xy=(%0d,%0d)",
                 k, bus.eng_start, bus.eng_x, bus.eng_y, en_edge, acc_before, exp_st, k % XS, (k / XS) % YS);
      end
      for (int i = 0; i < N; i++) if (bus.eng_start[i]) begin
        eact[i] = 1; epix[i] = k; last_se = i;
        ecnt[i] = rand_dly ? int'($urandom_range(2, 10)) : dly[i];
        edep[i] = DW'(int'(bus.eng_x) + XS * int'(bus.eng_y));
      end
      if (k < 4) start_cyc[k] = cyc;
      last_sx = int'(bus.eng_x);
      start_cnt++;
    end
    n_cmp++;
    if (bus.busy !== (start_cnt != out_cnt)) begin
      n_bad++; $display("FAIL busy @%0d: got %b want %b", cyc, bus.busy, start_cnt != out_cnt);
    end
    n_cmp++;
    if (bus.proto_err !== exp_perr) begin
      n_bad++; $display("FAIL proto_err @%0d: got %b want %b", cyc, bus.proto_err, exp_perr);
    end
    exp_v = (out_cnt < start_cnt) && (out_cnt < 1024) && done_at[out_cnt] >= 0 && done_at[out_cnt] < cyc;
    n_cmp++;
    if (bus.out_valid !== exp_v) begin
      n_bad++; $display("FAIL out_valid @%0d pix %0d: got %b want %b", cyc, out_cnt, bus.out_valid, exp_v);
    end
    if (bus.out_valid === 1'b1) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      j = out_cnt;
      exp_d = DW'((j % XS) + XS * ((j / XS) % YS));
      n_cmp++;
      if (bus.out_depth !== exp_d || bus.out_x !== 10'(j % XS) || bus.out_y !== 9'((j / XS) % YS)
          || bus.out_sof !== ((j % (XS * YS)) == 0) || bus.out_eol !== ((j % XS) == XS - 1)) begin
        n_bad++;
        $display("FAIL pixel[%0d]: got d=%0d xy=(%0d,%0d) sof=%b eol=%b, want d=%0d xy=(%0d,%0d) sof=%b eol=%b",
                 j, bus.out_depth, bus.out_x, bus.out_y, bus.out_sof, bus.out_eol,
                 exp_d, j % XS, (j / XS) % YS, (j % (XS * YS)) == 0, (j % XS) == XS - 1);
      end
    end
    rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    bus.out_ready = rdy;
    last_acc = (bus.out_valid === 1'b1) && rdy;
    if (last_acc) out_cnt++;
    dn = '0;
    for (int i = 0; i < N; i++) dep[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < N; i++) if (eact[i]) begin
      ecnt[i]--;
      if (ecnt[i] <= 0) begin
        dn[i] = 1'b1; dep[i*DW +: DW] = edep[i]; eact[i] = 0;
        if (epix[i] < 1024) done_at[epix[i]] = cyc;
        if (epix[i] == 0 && first_done0_cyc < 0) first_done0_cyc = cyc;
      end
    end
    if (spur) begin
      dn[2] = 1'b1; dep[2*DW +: DW] = 8'hAA; exp_perr = 1; spur = 0;
    end
    bus.eng_done  = dn;
    bus.eng_depth = dep;
  endtask

  task automatic drain();
    int t;
    bus.enable = 1'b0; rdy_mode = 0; t = 0;
    while (start_cnt != out_cnt && t < 200) begin step(); t++; end
    n_cmp++;
    if (start_cnt != out_cnt) begin
      n_bad++; $display("FAIL drain: issued %0d, accepted %0d", start_cnt, out_cnt);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.eng_start, bus.eng_x, bus.eng_y, bus.out_valid, bus.out_depth, bus.out_x, bus.out_y,
         bus.out_sof, bus.out_eol, bus.busy, bus.proto_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got start=%b valid=%b sof=%b busy=%b perr=%b, want all 0",
                        bus.eng_start, bus.out_valid, bus.out_sof, bus.busy, bus.proto_err);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int en_cyc, t;
    do_reset();
    rand_dly = 0; rdy_mode = 0;
    for (int i = 0; i < N; i++) dly[i] = 5;
    bus.enable = 1'b1; en_cyc = cyc; t = 0;
    while (out_cnt < 9 && t < 120) begin step(); t++; end
    n_cmp++;
    if (out_cnt < 9) begin n_bad++; $display("FAIL basic_count: got %0d outputs want 9", out_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (start_cyc[k] != en_cyc + 1 + k) begin
        n_bad++; $display("FAIL basic_start_cycle[%0d]: got %0d want %0d", k, start_cyc[k], en_cyc + 1 + k);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back_delays();
    int t;
    do_reset();
    dly[0] = 9; dly[1] = 2; dly[2] = 2; dly[3] = 2;
    bus.enable = 1'b1; t = 0;
    while (out_cnt < 4 && t < 80) begin step(); t++; end
    n_cmp++;
    if (first_done0_cyc < 0 || first_valid_cyc != first_done0_cyc + 1) begin
      n_bad++; $display("FAIL done_to_valid: got valid@%0d want %0d", first_valid_cyc, first_done0_cyc + 1);
    end
    drain();
  endtask

  task automatic test_stall();
    int t;
    logic [DW-1:0] d0; logic [9:0] x0; logic [8:0] y0;
    do_reset();
    for (int i = 0; i < N; i++) dly[i] = 5;
    rdy_mode = 1; bus.enable = 1'b1; t = 0;
    while (bus.out_valid !== 1'b1 && t < 40) begin step(); t++; end
    d0 = bus.out_depth; x0 = bus.out_x; y0 = bus.out_y;
    repeat (20) step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_depth !== d0 || bus.out_x !== x0 || bus.out_y !== y0 || start_cnt != 4) begin
      n_bad++; $display("FAIL stall_hold: got v=%b d=%0d xy=(%0d,%0d) starts=%0d, want v=1 d=%0d xy=(%0d,%0d) starts=4",
                        bus.out_valid, bus.out_depth, bus.out_x, bus.out_y, start_cnt, d0, x0, y0);
    end
    rdy_mode = 0; t = 0;
    while (out_cnt < 8 && t < 80) begin step(); t++; end
    n_cmp++;
    if (out_cnt < 8) begin n_bad++; $display("FAIL stall_resume: got %0d outputs want 8", out_cnt); end
    drain();
  endtask

  task automatic test_enable_drop();
    int t;
    do_reset();
    for (int i = 0; i < N; i++) dly[i] = 5;
    bus.enable = 1'b1;
    repeat (3) step();
    bus.enable = 1'b0;
    repeat (25) step();
    n_cmp++;
    if (start_cnt != 3 || out_cnt != 3 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL enable_drop: got starts=%0d outs=%0d busy=%b want 3/3/0", start_cnt, out_cnt, bus.busy);
    end
    bus.enable = 1'b1; t = 0;
    while (start_cnt < 4 && t < 10) begin step(); t++; end
    n_cmp++;
    if (last_se != 3 || last_sx != 3) begin
      n_bad++; $display("FAIL resume_start: got engine %0d x %0d want engine 3 x 3", last_se, last_sx);
    end
    drain();
  endtask

  task automatic test_spurious();
    int t, target;
    spur = 1;
    step();
    step();
    bus.enable = 1'b1; target = out_cnt + 8; t = 0;
    while (out_cnt < target && t < 100) begin step(); t++; end
    repeat (3) step();
    n_cmp++;
    if (bus.proto_err !== 1'b1 || out_cnt < target) begin
      n_bad++; $display("FAIL spurious: got perr=%b outs=%0d want perr=1 outs>=%0d", bus.proto_err, out_cnt, target);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    int t;
    for (int i = 0; i < N; i++) dly[i] = 20;
    bus.enable = 1'b1; t = 0;
    while (start_cnt < start_cnt - out_cnt + out_cnt + 0 && 0) step();
    while ((start_cnt - out_cnt) < 4 && t < 40) begin step(); t++; end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.eng_start, bus.eng_x, bus.eng_y, bus.out_valid, bus.out_depth, bus.out_x, bus.out_y,
         bus.out_sof, bus.out_eol, bus.busy, bus.proto_err} !== '0) begin
      n_bad++; $display("FAIL midop_reset_outputs: got start=%b valid=%b busy=%b perr=%b, want all 0",
                        bus.eng_start, bus.out_valid, bus.busy, bus.proto_err);
    end
    do_reset();
    for (int i = 0; i < N; i++) dly[i] = 5;
    bus.enable = 1'b1; t = 0;
    while (start_cnt < 1 && t < 10) begin step(); t++; end
    n_cmp++;
    if (last_se != 0 || last_sx != 0 || start_cnt != 1) begin
      n_bad++; $display("FAIL post_reset_start: got engine %0d x %0d want engine 0 x 0", last_se, last_sx);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    rand_dly = 1; rdy_mode = 2;
    repeat (300) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      step();
    end
    rand_dly = 0;
    for (int i = 0; i < N; i++) dly[i] = 3;
    drain();
    n_cmp++;
    if (out_cnt < 20) begin n_bad++; $display("FAIL random_throughput: got %0d outputs want >= 20", out_cnt); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rand_dly = 0; rdy_mode = 0;
    for (int i = 0; i < N; i++) dly[i] = 5;
    bus.enable = 1'b0; bus.eng_done = '0; bus.eng_depth = '0; bus.out_ready = 1'b1;
    clear_model();
    test_reset();
    test_basic();
    test_back_to_back_delays();
    test_stall();
    test_enable_drop();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
